// File: rtl/aes_pkg.sv
// Shared AES definitions: key-expansion FSM encoding, round count,
// GF(2^8) xtime and the word helpers used by the key schedule.
package aes_pkg;

   localparam int AES_ROUNDS = 10;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } kx_state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] rotword(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] rcon_word(input logic [7:0] rc);
      return {rc, 24'h0};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational: multiplicative inverse then affine map.
// Ports: x = input byte, y = substituted byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] x,
   output logic [7:0] y
);

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // x^254 = x^-1 for x != 0, and 0 maps to 0 as AES requires.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   logic [7:0] inv;

   always_comb begin
      inv = ginv(x);
      y   = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
   end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per clock into an 11-entry store.
// Ports: clk, rst (async high); key_valid/key_ready/key handshake;
// keys_valid level; rk_addr -> rk_data registered read (1 cycle).
// Option AES_KEYEXP_REVERSE_EN: read index mirrored (store[10-rk_addr]).
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int ROUNDS = AES_ROUNDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key,
   output logic         keys_valid,
   input  logic [3:0]   rk_addr,
   output logic [127:0] rk_data
);

   kx_state_t    state;
   kx_state_t    state_n;
   logic [127:0] store [0:ROUNDS];
   logic [127:0] prev;
   logic [3:0]   cnt;
   logic [7:0]   rcon;
   logic         hs;
   logic         last;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rw, sw, t;
   logic [127:0] rk_new;

   assign hs   = key_valid && key_ready;
   assign last = (cnt == 4'(ROUNDS));

   assign {w0, w1, w2, w3} = prev;
   assign rw = rotword(w3);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .x (rw[8*b +: 8]),
         .y (sw[8*b +: 8])
      );
   end

   always_comb begin
      logic [31:0] n0, n1, n2, n3;
      t      = sw ^ rcon_word(rcon);
      n0     = w0 ^ t;
      n1     = w1 ^ n0;
      n2     = w2 ^ n1;
      n3     = w3 ^ n2;
      rk_new = {n0, n1, n2, n3};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      key_ready = 1'b1;
      unique case (state)
         IDLE: begin
            if (hs) state_n = EXPAND;
         end
         EXPAND: begin
            key_ready = 1'b0;
            if (last) state_n = DONE;
         end
         DONE: begin
            if (hs) state_n = EXPAND;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j <= ROUNDS; j++) store[j] <= '0;
         prev       <= '0;
         cnt        <= '0;
         rcon       <= 8'h01;
         keys_valid <= 1'b0;
      end else if (hs) begin
         store[0]   <= key;
         prev       <= key;
         cnt        <= 4'd1;
         rcon       <= 8'h01;
         keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
         for (int j = 1; j <= ROUNDS; j++)
            if (cnt == 4'(j)) store[j] <= rk_new;
         prev <= rk_new;
         rcon <= xtime(rcon);
         // Counter parks at ROUNDS instead of wrapping.
         if (last) keys_valid <= 1'b1;
         else      cnt        <= cnt + 4'd1;
      end
   end

   logic [3:0]   idx;
   logic [127:0] rd;

   always_comb begin
`ifdef AES_KEYEXP_REVERSE_EN
      idx = 4'(ROUNDS) - rk_addr;
`else
      idx = rk_addr;
`endif
      rd = '0;
      if (rk_addr <= 4'(ROUNDS))
         for (int j = 0; j <= ROUNDS; j++)
            if (idx == 4'(j)) rd = store[j];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rk_data <= '0;
      else     rk_data <= rd;
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and zero-key schedules,
// rekey, back-to-back keys, mid-expansion reset and read-port bounds.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic         keys_valid;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;

   int ncmp = 0;
   int nerr = 0;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] Z_RK1    = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_RK10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] F_RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] F_RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   typedef struct {
      int           rnd;
      logic [127:0] exp;
   } vec_t;

   vec_t fips [11];

   aes_key_expand dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key        (key),
      .keys_valid (keys_valid),
      .rk_addr    (rk_addr),
      .rk_data    (rk_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] phys(input int r);
`ifdef AES_KEYEXP_REVERSE_EN
      return 4'(10 - r);
`else
      return 4'(r);
`endif
   endfunction

   // Offer k at a negedge; returns at the negedge after the handshake edge.
   task automatic offer(input logic [127:0] k, input bit hold);
      key       = k;
      key_valid = 1'b1;
      @(negedge clk);
      if (hold) key = ~k;
      else      key_valid = 1'b0;
   endtask

   // Counts edges from the handshake until keys_valid; expects 11.
   task automatic wait_done(input string name);
      int n;
      bit ready_bad;
      n = 1;
      ready_bad = 0;
      while (!keys_valid && n < 40) begin
         if (key_ready !== 1'b0) ready_bad = 1;
         @(negedge clk);
         n++;
      end
      key_valid = 1'b0;
      chk({name, "_latency"}, 128'(n), 128'd11);
      chk({name, "_ready_low"}, 128'(ready_bad), 128'd0);
      chk({name, "_ready_done"}, 128'(key_ready), 128'd1);
   endtask

   task automatic rd(input string name, input logic [3:0] a,
                     input logic [127:0] exp);
      rk_addr = a;
      @(negedge clk);
      chk(name, rk_data, exp);
   endtask

   initial begin
      fips[0]  = '{0,  FIPS_KEY};
      fips[1]  = '{1,  F_RK1};
      fips[2]  = '{2,  128'hf2c295f27a96b9435935807a7359f67f};
      fips[3]  = '{3,  128'h3d80477d4716fe3e1e237e446d7a883b};
      fips[4]  = '{4,  128'hef44a541a8525b7fb671253bdb0bad00};
      fips[5]  = '{5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
      fips[6]  = '{6,  128'h6d88a37a110b3efddbf98641ca0093fd};
      fips[7]  = '{7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
      fips[8]  = '{8,  128'head27321b58dbad2312bf5607f8d292f};
      fips[9]  = '{9,  128'hac7766f319fadc2128d12941575c006e};
      fips[10] = '{10, F_RK10};

      rst       = 1'b1;
      key_valid = 1'b0;
      key       = '0;
      rk_addr   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 128'(key_ready), 128'd1);
      chk("rst_kvalid", 128'(keys_valid), 128'd0);
      chk("rst_rkdata", rk_data, 128'h0);

      offer(128'h0, 0);
      wait_done("zero");
      rd("zero_rk0", phys(0), 128'h0);
      rd("zero_rk1", phys(1), Z_RK1);
      rd("zero_rk10", phys(10), Z_RK10);

      // Rekey from DONE with key_valid held through the expansion.
      offer(FIPS_KEY, 1);
      wait_done("rekey");
      for (int i = 0; i < 11; i++)
         rd($sformatf("fips_rk%0d", fips[i].rnd),
            phys(fips[i].rnd), fips[i].exp);

      rd("addr12", 4'd12, 128'h0);
      rd("addr15", 4'd15, 128'h0);
      rk_addr = 4'd0;
      @(negedge clk);
      chk("raw_addr0", rk_data,
`ifdef AES_KEYEXP_REVERSE_EN
          F_RK10
`else
          FIPS_KEY
`endif
      );

      // Back-to-back: FIPS key, then zero key in the first DONE cycle.
      offer(FIPS_KEY, 0);
      wait_done("b2b_a");
      offer(128'h0, 0);
      chk("b2b_kv_fall", 128'(keys_valid), 128'd0);
      wait_done("b2b_b");
      rd("b2b_rk10", phys(10), Z_RK10);
      rd("b2b_rk1", phys(1), Z_RK1);

      // Mid-expansion reads then asynchronous reset at handshake+5.
      offer(FIPS_KEY, 0);
      @(negedge clk);
      @(negedge clk);
      rd("mid_new_rk1", phys(1), F_RK1);
      rd("mid_old_rk10", phys(10), Z_RK10);
      chk("mid_kv", 128'(keys_valid), 128'd0);
      rst = 1'b1;
      #1;
      chk("arst_kvalid", 128'(keys_valid), 128'd0);
      chk("arst_ready", 128'(key_ready), 128'd1);
      chk("arst_rkdata", rk_data, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 11; i++)
         rd($sformatf("arst_rk%0d", i), 4'(i), 128'h0);
      repeat (3) @(negedge clk);
      chk("arst_kv_stays", 128'(keys_valid), 128'd0);

      offer(FIPS_KEY, 0);
      wait_done("fresh");
      rd("fresh_rk10", phys(10), F_RK10);
      rd("fresh_rk5", phys(5), fips[5].exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
